// File: rtl/cpu_clk_pkg.sv
// Shared types and default ratios for the processor clock sequencer.
//   state_e          : sequencer state encoding
//   DIV_*_DEF        : default half-period-minus-one ratios (board clocks)
//   CNT_W/CYC_W_DEF  : default divider and cycle counter widths
package cpu_clk_pkg;

    typedef enum logic [1:0] {
        HALTED   = 2'd0,
        RUN      = 2'd1,
        STEP     = 2'd2,
        STOPPING = 2'd3
    } state_e;

    localparam int unsigned DIV_FAST_DEF = 1;
    localparam int unsigned DIV_SLOW_DEF = 2500;
    localparam int unsigned CNT_W_DEF    = 32;
    localparam int unsigned CYC_W_DEF    = 32;

endpackage

// File: rtl/clk_phase_counter.sv
// Half-period counter with a ratio latch that only updates at phase start.
//   clk, reset   : board clock, async active-low reset
//   en_i         : count this clk
//   clr_i        : force count back to zero (takes priority over en_i)
//   div_nxt_i    : candidate ratio, adopted only while count is zero
//   tc_c_o       : combinational terminal count (count reached current ratio)
module clk_phase_counter
    import cpu_clk_pkg::*;
#(
    parameter int unsigned CNT_W = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en_i,
    input  logic             clr_i,
    input  logic [CNT_W-1:0] div_nxt_i,
    output logic             tc_c_o
);

    logic [CNT_W-1:0] count_q, count_d;
    logic [CNT_W-1:0] div_q, div_d;
    logic [CNT_W-1:0] div_cur;

    // Ratio for the phase in progress: a new one is taken only at count zero,
    // so a change never shortens a half-period already under way.
    always_comb begin
        div_cur = (count_q == '0) ? div_nxt_i : div_q;
        div_d   = div_cur;
        tc_c_o  = en_i && (count_q == div_cur);
        count_d = count_q;
        if (clr_i) begin
            count_d = '0;
        end else if (en_i) begin
            count_d = tc_c_o ? '0 : count_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count_q <= '0;
            div_q   <= '0;
        end else begin
            count_q <= count_d;
            div_q   <= div_d;
        end
    end

endmodule

// File: rtl/cpu_clock_controller.sv
// Processor clock sequencer: divides the board clock into cpu_clk and applies
// run / single-step / halt control so the core always stops with cpu_clk low.
//   clk, reset   : board clock, async active-low reset
//   set_freq     : 1 = fast ratio, 0 = slow ratio
//   run_req      : pulse, start free running (blocked while halt is high)
//   step_req     : pulse, run exactly one cpu_clk period
//   halt_req     : pulse, stop after the current period
//   halt         : level from core, stops free running
//   cpu_clk      : divided processor clock
//   cpu_tick     : pulse in the clk where cpu_clk rises
//   running      : RUN, STEP or STOPPING
//   halted       : HALTED
//   cycle_count  : number of cpu_clk rising edges (wrapping)
module cpu_clock_controller
    import cpu_clk_pkg::*;
#(
    parameter int unsigned DIV_FAST  = DIV_FAST_DEF,
    parameter int unsigned DIV_SLOW  = DIV_SLOW_DEF,
    parameter int unsigned CNT_W     = CNT_W_DEF,
    parameter int unsigned CYC_W     = CYC_W_DEF,
    parameter bit          START_RUN = 1'b1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             set_freq,
    input  logic             run_req,
    input  logic             step_req,
    input  logic             halt_req,
    input  logic             halt,
    output logic             cpu_clk,
    output logic             cpu_tick,
    output logic             running,
    output logic             halted,
    output logic [CYC_W-1:0] cycle_count
);

    localparam state_e RST_STATE = START_RUN ? RUN : HALTED;

    state_e           state_q, state_d;
    logic             cpu_clk_q, cpu_clk_d;
    logic             cpu_tick_q, cpu_tick_d;
    logic             running_q, running_d;
    logic             halted_q, halted_d;
    logic [CYC_W-1:0] cycle_count_q, cycle_count_d;

    logic             en_c;
    logic             clr_c;
    logic             tc_c;
    logic [CNT_W-1:0] div_sel_c;

    // Divider runs while sequencing; STOPPING with cpu_clk low stops at once.
    always_comb begin
        en_c      = (state_q == RUN) || (state_q == STEP) ||
                    ((state_q == STOPPING) && cpu_clk_q);
        clr_c     = !en_c;
        div_sel_c = set_freq ? CNT_W'(DIV_FAST) : CNT_W'(DIV_SLOW);
    end

    clk_phase_counter #(
        .CNT_W (CNT_W)
    ) u_phase (
        .clk       (clk),
        .reset     (reset),
        .en_i      (en_c),
        .clr_i     (clr_c),
        .div_nxt_i (div_sel_c),
        .tc_c_o    (tc_c)
    );

    // Next state, clock phase, tick and cycle count.
    always_comb begin
        logic rise;
        logic fall;
        rise          = tc_c && !cpu_clk_q;
        fall          = tc_c && cpu_clk_q;
        state_d       = state_q;
        cpu_clk_d     = tc_c ? !cpu_clk_q : cpu_clk_q;
        cpu_tick_d    = rise;
        cycle_count_d = cycle_count_q + CYC_W'(rise);

        unique case (state_q)
            HALTED: begin
                // halt_req has nothing to stop here, so step outranks run.
                if (step_req) begin
                    state_d = STEP;
                end else if (run_req && !halt) begin
                    state_d = RUN;
                end
            end
            RUN: begin
                if (halt_req || halt) begin
                    state_d = STOPPING;
                end
            end
            STEP: begin
                // The rising edge is the step; STOPPING then finishes the low edge.
                if (halt_req || rise) begin
                    state_d = STOPPING;
                end
            end
            STOPPING: begin
                if (!cpu_clk_q || fall) begin
                    state_d = HALTED;
                end
            end
            default: state_d = HALTED;
        endcase

        running_d = (state_d != HALTED);
        halted_d  = (state_d == HALTED);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q       <= RST_STATE;
            cpu_clk_q     <= 1'b0;
            cpu_tick_q    <= 1'b0;
            running_q     <= START_RUN;
            halted_q      <= !START_RUN;
            cycle_count_q <= '0;
        end else begin
            state_q       <= state_d;
            cpu_clk_q     <= cpu_clk_d;
            cpu_tick_q    <= cpu_tick_d;
            running_q     <= running_d;
            halted_q      <= halted_d;
            cycle_count_q <= cycle_count_d;
        end
    end

    assign cpu_clk     = cpu_clk_q;
    assign cpu_tick    = cpu_tick_q;
    assign running     = running_q;
    assign halted      = halted_q;
    assign cycle_count = cycle_count_q;

endmodule

// File: tb/tb_cpu_clock_controller.sv
// Directed bench for cpu_clock_controller with DIV_FAST=0, DIV_SLOW=3.
// Two instances: u_dut starts in RUN, u_dut0 starts HALTED.
module tb_cpu_clock_controller;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset, set_freq, run_req, step_req, halt_req, halt;
    logic        run0_req, step0_req;

    logic        cpu_clk, cpu_tick, running, halted;
    logic [31:0] cycle_count;
    logic        clk0, tick0, running0, halted0;
    logic [31:0] cycle0;

    int tests = 0;
    int fails = 0;

    cpu_clock_controller #(
        .DIV_FAST (0), .DIV_SLOW (3), .CNT_W (32), .CYC_W (32), .START_RUN (1'b1)
    ) u_dut (
        .clk (clk), .reset (reset), .set_freq (set_freq),
        .run_req (run_req), .step_req (step_req), .halt_req (halt_req), .halt (halt),
        .cpu_clk (cpu_clk), .cpu_tick (cpu_tick), .running (running),
        .halted (halted), .cycle_count (cycle_count)
    );

    cpu_clock_controller #(
        .DIV_FAST (0), .DIV_SLOW (3), .CNT_W (32), .CYC_W (32), .START_RUN (1'b0)
    ) u_dut0 (
        .clk (clk), .reset (reset), .set_freq (set_freq),
        .run_req (run0_req), .step_req (step0_req), .halt_req (1'b0), .halt (1'b0),
        .cpu_clk (clk0), .cpu_tick (tick0), .running (running0),
        .halted (halted0), .cycle_count (cycle0)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic cyc(input int n);
        repeat (n) tick();
    endtask

    // Count cpu_tick pulses and cpu_clk-high cycles over n clocks.
    task automatic watch(input bit sel0, input int n, output int ticks, output int highs);
        ticks = 0;
        highs = 0;
        repeat (n) begin
            tick();
            if (sel0) begin
                ticks += int'(tick0);
                highs += int'(clk0);
            end else begin
                ticks += int'(cpu_tick);
                highs += int'(cpu_clk);
            end
        end
    endtask

    initial begin
        logic [15:0] pat, tpat;
        logic [7:0]  pat8;
        int          t, h;

        reset = 1'b0; set_freq = 1'b0; run_req = 1'b0; step_req = 1'b0;
        halt_req = 1'b0; halt = 1'b0; run0_req = 1'b0; step0_req = 1'b0;
        pat = '0; tpat = '0; pat8 = '0;

        // Reset values
        cyc(2);
        chk("rst_cpu_clk", 32'(cpu_clk), 32'd0);
        chk("rst_tick", 32'(cpu_tick), 32'd0);
        chk("rst_cycles", cycle_count, 32'd0);
        chk("rst_running", 32'(running), 32'd1);
        chk("rst_halted", 32'(halted), 32'd0);
        chk("rst0_halted", 32'(halted0), 32'd1);
        chk("rst0_running", 32'(running0), 32'd0);

        // Free run from reset: first rise at clk 4, period 8
        reset = 1'b1;
        cyc(3);
        chk("pre_rise_low", 32'(cpu_clk), 32'd0);
        tick();
        chk("first_rise", 32'(cpu_clk), 32'd1);
        chk("first_tick", 32'(cpu_tick), 32'd1);
        chk("first_count", cycle_count, 32'd1);
        for (int i = 0; i < 16; i++) begin
            tick();
            pat[i]  = cpu_clk;
            tpat[i] = cpu_tick;
        end
        chk("run_pattern", 32'(pat), 32'h8787);
        chk("tick_pattern", 32'(tpat), 32'h8080);
        chk("count_3", cycle_count, 32'd3);

        // halt_req one clk after a rise: high phase completes
        halt_req = 1'b1; tick(); halt_req = 1'b0;
        chk("stop_hi_running", 32'(running), 32'd1);
        chk("stop_hi_clk", 32'(cpu_clk), 32'd1);
        cyc(2);
        chk("stop_hi_still", 32'(cpu_clk), 32'd1);
        chk("stop_hi_not_halted", 32'(halted), 32'd0);
        tick();
        chk("stop_hi_fall", 32'(cpu_clk), 32'd0);
        chk("stop_hi_halted", 32'(halted), 32'd1);
        chk("stop_hi_not_run", 32'(running), 32'd0);
        watch(1'b0, 20, t, h);
        chk("halted_no_ticks", 32'(t), 32'd0);
        chk("halted_no_high", 32'(h), 32'd0);

        // halt_req during low phase
        run_req = 1'b1; tick(); run_req = 1'b0;
        chk("run_running", 32'(running), 32'd1);
        tick();
        chk("run_low", 32'(cpu_clk), 32'd0);
        halt_req = 1'b1; tick(); halt_req = 1'b0;
        chk("stop_lo_stopping", 32'(halted), 32'd0);
        tick();
        chk("stop_lo_halted", 32'(halted), 32'd1);
        chk("stop_lo_clk", 32'(cpu_clk), 32'd0);
        watch(1'b0, 20, t, h);
        chk("stop_lo_no_ticks", 32'(t), 32'd0);
        chk("stop_lo_no_high", 32'(h), 32'd0);
        chk("stop_lo_count", cycle_count, 32'd3);

        // halt level blocks run but not step
        halt = 1'b1;
        run_req = 1'b1; tick(); run_req = 1'b0;
        chk("halt_blocks_run", 32'(halted), 32'd1);
        watch(1'b0, 40, t, h);
        chk("halt_run_no_ticks", 32'(t), 32'd0);
        chk("halt_run_no_high", 32'(h), 32'd0);
        step_req = 1'b1; tick(); step_req = 1'b0;
        chk("halt_step_running", 32'(running), 32'd1);
        watch(1'b0, 40, t, h);
        chk("halt_step_ticks", 32'(t), 32'd1);
        chk("halt_step_high", 32'(h), 32'd4);
        chk("halt_step_halted", 32'(halted), 32'd1);
        chk("halt_step_count", cycle_count, 32'd4);

        // Resume free running after halt drops
        halt = 1'b0;
        run_req = 1'b1; tick(); run_req = 1'b0;
        cyc(4);
        chk("resume_tick", 32'(cpu_tick), 32'd1);
        chk("resume_count", cycle_count, 32'd5);

        // Ratio change mid half-period: current phase completes first
        tick();
        set_freq = 1'b1;
        for (int i = 0; i < 8; i++) begin
            tick();
            pat8[i] = cpu_clk;
        end
        chk("fast_pattern", 32'(pat8), 32'hAB);
        chk("fast_count", cycle_count, 32'd8);

        // halt_req + run_req together in RUN
        set_freq = 1'b0;
        halt_req = 1'b1; run_req = 1'b1; tick(); halt_req = 1'b0; run_req = 1'b0;
        chk("hr_run_running", 32'(running), 32'd1);
        chk("hr_run_clk", 32'(cpu_clk), 32'd1);
        cyc(2);
        chk("hr_run_high", 32'(cpu_clk), 32'd1);
        tick();
        chk("hr_run_fall", 32'(cpu_clk), 32'd0);
        chk("hr_run_halted", 32'(halted), 32'd1);
        chk("hr_run_count", cycle_count, 32'd8);

        // halt_req + step_req together in HALTED
        halt_req = 1'b1; step_req = 1'b1; tick(); halt_req = 1'b0; step_req = 1'b0;
        chk("hs_step_running", 32'(running), 32'd1);
        watch(1'b0, 8, t, h);
        chk("hs_step_ticks", 32'(t), 32'd1);
        chk("hs_step_high", 32'(h), 32'd4);
        chk("hs_step_halted", 32'(halted), 32'd1);
        chk("hs_step_count", cycle_count, 32'd9);

        // Async reset in the middle of a high phase
        run_req = 1'b1; tick(); run_req = 1'b0;
        cyc(5);
        chk("pre_rst_high", 32'(cpu_clk), 32'd1);
        chk("pre_rst_count", cycle_count, 32'd10);
        reset = 1'b0;
        #1;
        chk("async_rst_clk", 32'(cpu_clk), 32'd0);
        chk("async_rst_count", cycle_count, 32'd0);
        chk("async_rst_tick", 32'(cpu_tick), 32'd0);
        chk("async_rst_running", 32'(running), 32'd1);
        tick();
        reset = 1'b1;

        // START_RUN=0 instance: single step
        chk("s0_halted", 32'(halted0), 32'd1);
        step0_req = 1'b1; tick(); step0_req = 1'b0;
        chk("s0_running", 32'(running0), 32'd1);
        cyc(3);
        chk("s0_pre_rise", 32'(clk0), 32'd0);
        tick();
        chk("s0_rise", 32'(clk0), 32'd1);
        chk("s0_tick", 32'(tick0), 32'd1);
        chk("s0_count", cycle0, 32'd1);
        cyc(3);
        chk("s0_high", 32'(clk0), 32'd1);
        tick();
        chk("s0_fall", 32'(clk0), 32'd0);
        chk("s0_halted_after", 32'(halted0), 32'd1);
        watch(1'b1, 40, t, h);
        chk("s0_no_ticks", 32'(t), 32'd0);
        chk("s0_no_high", 32'(h), 32'd0);
        chk("s0_final_count", cycle0, 32'd1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/cpu_clock_controller.md
Name: cpu_clock_controller

Overview:
Sequences the processor clock. From the board clock it generates a divided processor clock `cpu_clk` and applies run, single-step and halt control. It sits between the board clock and the MIPS core. It replaces free-running division with a state machine, so the core always stops with `cpu_clk` low and single-steps exactly one full period. It also keeps a count of processor cycles for the debug display.

Parameters:
- DIV_FAST, 1, half-period minus one (board clocks) when `set_freq`=1
- DIV_SLOW, 2500, half-period minus one (board clocks) when `set_freq`=0
- CNT_W, 32, divider counter width; must hold DIV_SLOW
- CYC_W, 32, `cycle_count` width
- START_RUN, 1, 1 = enter RUN after reset, 0 = enter HALTED

Ports:
- clk  in  1  board clock; all logic on its rising edge
- reset  in  1  asynchronous, active-low reset
- set_freq  in  1  1 = fast ratio, 0 = slow ratio
- run_req  in  1  one-clk pulse: start free running
- step_req  in  1  one-clk pulse: execute one cpu_clk period
- halt_req  in  1  one-clk pulse: stop after current period
- halt  in  1  level from core (halt instruction): blocks free run
- cpu_clk  out  1  divided processor clock (registered)
- cpu_tick  out  1  one-clk pulse in the cycle cpu_clk goes 0->1
- running  out  1  high in RUN, STEP and STOPPING
- halted  out  1  high in HALTED
- cycle_count  out  CYC_W  number of cpu_clk rising edges, wraps at 2^CYC_W

Behaviour:
- Reset (reset=0, asynchronous):
  - cpu_clk=0, cpu_tick=0, count=0, cycle_count=0.
  - state = RUN if START_RUN else HALTED; running/halted follow state.
- Divider:
  - Active in RUN, STEP, STOPPING.
  - count increments each clk.
  - When count==div: cpu_clk toggles and count returns to 0.
  - Half-period = div+1 clk cycles; full period = 2*(div+1).
- Ratio sampling:
  - div is latched from set_freq only when count==0.
  - A ratio change never truncates a half-period in progress.
- cpu_tick and cycle_count:
  - cpu_tick=1 exactly in the clk cycle where registered cpu_clk becomes 1.
  - cycle_count increments in that same cycle.
- States:
  - HALTED: cpu_clk=0, count held at 0.
    - halt_req: ignored.
    - step_req: go to STEP.
    - run_req with halt=0: go to RUN.
    - run_req with halt=1: ignored.
  - RUN: free toggling.
    - halt_req, or halt=1: go to STOPPING.
  - STEP: toggling.
    - On the rising toggle, go to STOPPING in the same cycle.
    - halt_req in STEP: go to STOPPING.
  - STOPPING:
    - If cpu_clk=1: keep counting; on the falling toggle, go to HALTED with count=0.
    - If cpu_clk=0: go to HALTED next clk, count cleared, no further edge.
- Request priority when pulses coincide: halt_req > step_req > run_req.
- Requests outside their listed states are ignored (no queuing).
  - Example: run_req during STOPPING is dropped.
- Stop guarantee: cpu_clk never stops high; every rising edge is followed by its falling edge before HALTED.
- halt rising while in STEP does not abort the step.
- Reset asserted mid-period: immediate return to reset values; a partial high phase is permitted only because reset is asynchronous.
- Outputs are registered; no combinational path from request inputs to cpu_clk.

Decomposition:
- Package cpu_clk_pkg:
  - state enum {HALTED, RUN, STEP, STOPPING}.
  - Default ratio constants DIV_FAST/DIV_SLOW.
- One sub-module, clk_phase_counter:
  - Inputs: enable, clear, latch-div.
  - Outputs: terminal-count pulse and current div.
  - Counter plus div latch.
- FSM, cpu_clk register, tick and cycle counter stay in the top.

Test Plan (bench overrides DIV_FAST=0, DIV_SLOW=3):
- Reset with START_RUN=1, set_freq=0, no requests: cpu_clk period is 8 clk (4 high/4 low); first rise at clk 4 after reset release; cpu_tick pulses once per period; cycle_count=3 after the third rise.
- START_RUN=0, step_req single pulse: exactly one rise (cpu_tick once) then fall 4 clk later; halted=1 on the next clk; cycle_count=1; no further edges over 40 clk.
- RUN, halt_req pulsed 1 clk after a rising edge: cpu_clk stays high its remaining 3 clk, falls, then halted=1; with halt_req during a low phase, halted=1 next clk and cpu_clk remains 0.
- HALTED with halt=1: run_req produces no edges over 40 clk; step_req still produces one full period; after halt=0 and run_req, free running resumes.
- RUN, set_freq 0->1 mid-half-period: the current half-period completes at 4 clk; subsequent half-periods are 1 clk (period 2).
- Same-cycle halt_req+step_req in HALTED: STEP taken, one period, HALTED. Same-cycle halt_req+run_req in RUN: STOPPING. Reset pulsed mid high phase: cpu_clk=0 and cycle_count=0 immediately.
